// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles little-endian words, writes them to
// instruction memory, verifies a trailing XOR checksum and then releases the CPU.
module imem_loader #(
  parameter int          MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_start,
  output logic        busy,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, RUN, ERR} state_t;

  state_t      state;
  logic [15:0] len;
  logic [15:0] len_full;
  logic [7:0]  csum;
  logic [1:0]  bidx;
  logic [23:0] asm_p0;
  logic        accept;

  function automatic logic too_big(input logic [15:0] n);
    return 32'(n) > 32'(MAX_WORDS);
  endfunction

  function automatic logic [31:0] word_addr(input logic [15:0] k);
    return BASE_ADDR + {14'd0, k, 2'b00};
  endfunction

  assign in_ready  = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
  assign busy      = in_ready;
  assign cpu_start = (state == RUN);
  assign error     = (state == ERR);
  assign accept    = in_valid && in_ready;
  assign len_full  = {in_data, len[7:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LEN0;
      len          <= 16'd0;
      csum         <= 8'd0;
      bidx         <= 2'd0;
      asm_p0       <= 24'd0;
      imem_we      <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wdata   <= 32'd0;
      words_loaded <= 16'd0;
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        // The checksum byte itself is compared, never folded into the XOR.
        if (state != CSUM) csum <= csum ^ in_data;
        case (state)
          LEN0: begin
            len[7:0] <= in_data;
            state    <= LEN1;
          end
          LEN1: begin
            len[15:8] <= in_data;
            if (too_big(len_full))       state <= ERR;
            else if (len_full == 16'd0)  state <= CSUM;
            else                         state <= DATA;
          end
          DATA: begin
            bidx <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              imem_we      <= 1'b1;
              imem_addr    <= word_addr(words_loaded);
              imem_wdata   <= {in_data, asm_p0};
              words_loaded <= words_loaded + 16'd1;
              if (words_loaded == len - 16'd1) state <= CSUM;
            end else begin
              asm_p0 <= {in_data, asm_p0[23:8]};
            end
          end
          CSUM: state <= (in_data == csum) ? RUN : ERR;
          default: state <= state;
        endcase
      end
    end
  end

endmodule
